// File: rtl/mem_arb_pkg.sv
// Shared types and reset constants for the mem_arbiter block.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        GNT_MEM = 1'b0,
        GNT_IF  = 1'b1
    } gnt_t;

    localparam logic        RST_WE_N     = 1'b1;
    localparam logic        RST_OE_N     = 1'b1;
    localparam logic [31:0] RST_RDATA    = 32'h0;
    // "served last" starts at IF so the first collision after reset goes to MEM
    localparam gnt_t        RST_LAST_GNT = GNT_IF;

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle between the MEM/fetch requesters, the arbiter and the SRAM pins.
// slave = arbiter side, master = environment (requesters + SRAM).
interface mem_arb_if #(parameter int SRAM_AW = 18);
    logic                mem_req;
    logic                mem_we;
    logic [31:0]         mem_addr;
    logic [31:0]         mem_wdata;
    logic                mem_ack;
    logic [31:0]         mem_rdata;
    logic                if_req;
    logic [31:0]         if_addr;
    logic                if_ack;
    logic [31:0]         if_rdata;
    logic [SRAM_AW-1:0]  sram_addr;
    logic [15:0]         sram_wdata;
    logic [15:0]         sram_rdata;
    logic                sram_we_n;
    logic                sram_oe_n;
    logic                busy;

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, if_req, if_addr, sram_rdata,
        output mem_ack, mem_rdata, if_ack, if_rdata,
               sram_addr, sram_wdata, sram_we_n, sram_oe_n, busy
    );

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, if_req, if_addr, sram_rdata,
        input  mem_ack, mem_rdata, if_ack, if_rdata,
               sram_addr, sram_wdata, sram_we_n, sram_oe_n, busy
    );
endinterface

// File: rtl/mem_arb_wait_cnt.sv
// Phase wait timer: down-counter, reload on phase entry, tc when it reaches zero.
module mem_arb_wait_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         cnt_en,
    output logic         tc
);
    logic [W-1:0] cnt_q;

    // Load wins over count; hold at zero once expired.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      cnt_q <= '0;
        else if (load)                 cnt_q <= load_val;
        else if (cnt_en && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end

    assign tc = (cnt_q == '0);
endmodule

// File: rtl/mem_arbiter.sv
// Two-port (MEM stage / fetch) arbiter onto a 16-bit SRAM; each 32-bit access
// is a LO then HI halfword phase of WAIT_CYCLES cycles each.
// Optional: define MEM_ARB_RR_EN for round-robin on simultaneous requests
// (default build: fixed MEM priority).
//
// state   | meaning
// IDLE    | waiting; grants and latches a request
// LO      | low halfword access (sram_addr bit0 = 0)
// HI      | high halfword access (sram_addr bit0 = 1)
// DONE    | one-cycle ack to the granted port, no new grant
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic      clk,
    input  logic      rst,
    mem_arb_if.slave  bus
);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t             state_q, state_d;
    gnt_t               gnt_q, gnt_sel;
    logic               we_q;
    logic [SRAM_AW-2:0] addr_q;
    logic [31:0]        wdata_q;
    logic [15:0]        rdata_lo_q;
    logic [31:0]        mem_rdata_q, if_rdata_q;
    logic               grant, tc, load, cnt_en;

    logic               mem_ack, if_ack, busy, sram_we_n, sram_oe_n;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_wdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_addr[31:SRAM_AW+1], bus.mem_addr[1:0],
                                bus.if_addr[31:SRAM_AW+1], bus.if_addr[1:0]};

    assign grant  = (state_q == ST_IDLE) && (bus.mem_req || bus.if_req);
    assign load   = grant || ((state_q == ST_LO) && tc);
    assign cnt_en = (state_q == ST_LO) || (state_q == ST_HI);

    mem_arb_wait_cnt #(.W(4)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (WAIT_LOAD),
        .cnt_en   (cnt_en),
        .tc       (tc)
    );

`ifdef MEM_ARB_RR_EN
    gnt_t last_gnt_q;

    // Remember who was served last to alternate on collisions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       last_gnt_q <= RST_LAST_GNT;
        else if (grant) last_gnt_q <= gnt_sel;
    end

    // Collision goes to the port not served last.
    always_comb begin
        gnt_sel = GNT_MEM;
        if (bus.mem_req && bus.if_req) gnt_sel = (last_gnt_q == GNT_MEM) ? GNT_IF : GNT_MEM;
        else if (bus.if_req)           gnt_sel = GNT_IF;
    end
`else
    // Fixed priority: MEM wins any collision.
    always_comb begin
        gnt_sel = GNT_MEM;
        if (!bus.mem_req && bus.if_req) gnt_sel = GNT_IF;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; phases advance on the wait-counter terminal count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant) state_d = ST_LO;
            ST_LO:   if (tc)    state_d = ST_HI;
            ST_HI:   if (tc)    state_d = ST_DONE;
            default:            state_d = ST_IDLE;
        endcase
    end

    // Latch the granted request; fetch grants are always reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q   <= GNT_MEM;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            gnt_q   <= gnt_sel;
            we_q    <= (gnt_sel == GNT_MEM) ? bus.mem_we : 1'b0;
            addr_q  <= (gnt_sel == GNT_MEM) ? bus.mem_addr[SRAM_AW:2] : bus.if_addr[SRAM_AW:2];
            wdata_q <= bus.mem_wdata;
        end
    end

    // Read capture: low half staged, port register updated only at the HI end
    // so each port's rdata holds until its next read completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_lo_q  <= '0;
            mem_rdata_q <= RST_RDATA;
            if_rdata_q  <= RST_RDATA;
        end else if (!we_q && tc) begin
            if (state_q == ST_LO) rdata_lo_q <= bus.sram_rdata;
            if (state_q == ST_HI) begin
                if (gnt_q == GNT_MEM) mem_rdata_q <= {bus.sram_rdata, rdata_lo_q};
                else                  if_rdata_q  <= {bus.sram_rdata, rdata_lo_q};
            end
        end
    end

    // Output decode from state; IDLE values equal the reset values.
    always_comb begin
        mem_ack    = 1'b0;
        if_ack     = 1'b0;
        busy       = 1'b0;
        sram_we_n  = RST_WE_N;
        sram_oe_n  = RST_OE_N;
        sram_addr  = '0;
        sram_wdata = '0;
        case (state_q)
            ST_LO, ST_HI: begin
                busy      = 1'b1;
                sram_addr = {addr_q, (state_q == ST_HI)};
                if (we_q) begin
                    sram_we_n  = 1'b0;
                    sram_wdata = (state_q == ST_HI) ? wdata_q[31:16] : wdata_q[15:0];
                end else begin
                    sram_oe_n  = 1'b0;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                mem_ack = (gnt_q == GNT_MEM);
                if_ack  = (gnt_q == GNT_IF);
            end
            default: ;
        endcase
    end

    assign bus.mem_ack    = mem_ack;
    assign bus.if_ack     = if_ack;
    assign bus.busy       = busy;
    assign bus.sram_we_n  = sram_we_n;
    assign bus.sram_oe_n  = sram_oe_n;
    assign bus.sram_addr  = sram_addr;
    assign bus.sram_wdata = sram_wdata;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.if_rdata   = if_rdata_q;
endmodule
